// File: rtl/tx_core_serializer.sv
// tx_core_serializer: UART transmit engine.
// Pops one byte at a time from the Tx FIFO and shifts it out as
// start / 8 data / optional parity / 1-2 stop bits. Every bit is paced by BaudSig_i.
// Optional build macro TX_GAP_EN adds GapBits_i. It inserts a number of idle bit
// periods after each frame, before the next fetch can happen.
module tx_core_serializer #(
    parameter logic IDLE_LEVEL = 1'b1,
    parameter int   CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p_Enable_i,
    input  logic                 BaudSig_i,
    input  logic [7:0]           Data_i,
    input  logic                 p_Empty_i,
    output logic                 n_Rd_o,
    input  logic                 p_ParityEnable_i,
    input  logic                 ParityMethod_i,
    input  logic                 p_BigEnd_i,
    input  logic                 StopBits_i,
`ifdef TX_GAP_EN
    input  logic [3:0]           GapBits_i,
`endif
    output logic                 Tx_o,
    output logic                 p_Busy_o,
    output logic                 p_ByteSent_o,
    output logic [4:0]           State_o,
    output logic [3:0]           BitCounter_o,
    output logic [CNT_WIDTH-1:0] TxByteCnt_o
);

    // One-hot codes presented to the control core
    localparam logic [4:0] ST_INTERVAL  = 5'b00001;
    localparam logic [4:0] ST_STARTBIT  = 5'b00010;
    localparam logic [4:0] ST_DATABITS  = 5'b00100;
    localparam logic [4:0] ST_PARITYBIT = 5'b01000;
    localparam logic [4:0] ST_STOPBIT   = 5'b10000;

    // Internal states. IDLE, FETCH, LOAD, ARM and GAP all report as INTERVAL.
    // ARM waits for the first baud pulse after the byte is latched.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_LOAD   = 4'd2,
        S_ARM    = 4'd3,
        S_START  = 4'd4,
        S_DATA   = 4'd5,
        S_PARITY = 4'd6,
        S_STOP   = 4'd7
`ifdef TX_GAP_EN
        ,
        S_GAP    = 4'd8
`endif
    } txState_t;

    txState_t             state_r;
    logic [4:0]           stateOh_r;
    logic                 txLine_r;
    logic                 nRd_r;
    logic                 busy_r;
    logic                 byteSent_r;
    logic [3:0]           bitCnt_r;
    logic [CNT_WIDTH-1:0] byteCnt_r;
    logic [7:0]           shift_r;
    logic                 parEn_r;
    logic                 parityBit_r;
    logic                 bigEnd_r;
    logic                 twoStop_r;
`ifdef TX_GAP_EN
    logic [3:0]           gapCnt_r;
`endif

    // Even parity of a byte: XOR of all eight bits
    function automatic logic evenParity(input logic [7:0] d);
        return ^d;
    endfunction

    // Bit that goes on the wire next, taken from the head of the shift register
    function automatic logic headBit(input logic [7:0] sh, input logic bigEnd);
        return bigEnd ? sh[7] : sh[0];
    endfunction

    // Shift register after the head bit has been consumed
    function automatic logic [7:0] dropHead(input logic [7:0] sh, input logic bigEnd);
        return bigEnd ? {sh[6:0], 1'b0} : {1'b0, sh[7:1]};
    endfunction

    // Transmit FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            stateOh_r   <= ST_INTERVAL;
            txLine_r    <= IDLE_LEVEL;
            nRd_r       <= 1'b1;
            busy_r      <= 1'b0;
            byteSent_r  <= 1'b0;
            bitCnt_r    <= 4'd0;
            byteCnt_r   <= '0;
            shift_r     <= 8'd0;
            parEn_r     <= 1'b0;
            parityBit_r <= 1'b0;
            bigEnd_r    <= 1'b0;
            twoStop_r   <= 1'b0;
`ifdef TX_GAP_EN
            gapCnt_r    <= 4'd0;
`endif
        end else begin
            // Strobes are single-cycle unless re-asserted below
            nRd_r      <= 1'b1;
            byteSent_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (p_Enable_i && !p_Empty_i) begin
                        state_r <= S_FETCH;
                        nRd_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    // FIFO presents the byte during the following cycle
                    state_r <= S_LOAD;
                end
                S_LOAD: begin
                    // Frame data and its configuration are frozen here
                    shift_r     <= Data_i;
                    parEn_r     <= p_ParityEnable_i;
                    parityBit_r <= evenParity(Data_i) ^ ParityMethod_i;
                    bigEnd_r    <= p_BigEnd_i;
                    twoStop_r   <= StopBits_i;
                    state_r     <= S_ARM;
                end
                S_ARM: begin
                    if (BaudSig_i) begin
                        state_r   <= S_START;
                        stateOh_r <= ST_STARTBIT;
                        txLine_r  <= ~IDLE_LEVEL;
                    end
                end
                S_START: begin
                    if (BaudSig_i) begin
                        state_r   <= S_DATA;
                        stateOh_r <= ST_DATABITS;
                        bitCnt_r  <= 4'd0;
                        txLine_r  <= headBit(shift_r, bigEnd_r);
                        shift_r   <= dropHead(shift_r, bigEnd_r);
                    end
                end
                S_DATA: begin
                    if (BaudSig_i) begin
                        if (bitCnt_r == 4'd7) begin
                            bitCnt_r <= 4'd0;
                            if (parEn_r) begin
                                state_r   <= S_PARITY;
                                stateOh_r <= ST_PARITYBIT;
                                txLine_r  <= parityBit_r;
                            end else begin
                                state_r   <= S_STOP;
                                stateOh_r <= ST_STOPBIT;
                                txLine_r  <= IDLE_LEVEL;
                            end
                        end else begin
                            bitCnt_r <= bitCnt_r + 4'd1;
                            txLine_r <= headBit(shift_r, bigEnd_r);
                            shift_r  <= dropHead(shift_r, bigEnd_r);
                        end
                    end
                end
                S_PARITY: begin
                    if (BaudSig_i) begin
                        state_r   <= S_STOP;
                        stateOh_r <= ST_STOPBIT;
                        bitCnt_r  <= 4'd0;
                        txLine_r  <= IDLE_LEVEL;
                    end
                end
                S_STOP: begin
                    if (BaudSig_i) begin
                        if (twoStop_r && (bitCnt_r == 4'd0)) begin
                            bitCnt_r <= 4'd1;
                        end else begin
                            // End of frame: count it and go back to the interval
                            bitCnt_r   <= 4'd0;
                            byteSent_r <= 1'b1;
                            byteCnt_r  <= byteCnt_r + CNT_WIDTH'(1);
                            stateOh_r  <= ST_INTERVAL;
`ifdef TX_GAP_EN
                            if (GapBits_i != 4'd0) begin
                                state_r  <= S_GAP;
                                gapCnt_r <= GapBits_i;
                            end else begin
                                state_r <= S_IDLE;
                                busy_r  <= 1'b0;
                            end
`else
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
`endif
                        end
                    end
                end
`ifdef TX_GAP_EN
                S_GAP: begin
                    // Line stays idle for the requested number of bit periods
                    if (BaudSig_i) begin
                        if (gapCnt_r == 4'd1) begin
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            gapCnt_r <= gapCnt_r - 4'd1;
                        end
                    end
                end
`endif
                default: begin
                    state_r   <= S_IDLE;
                    stateOh_r <= ST_INTERVAL;
                    txLine_r  <= IDLE_LEVEL;
                    busy_r    <= 1'b0;
                    bitCnt_r  <= 4'd0;
                end
            endcase
        end
    end

    assign Tx_o         = txLine_r;
    assign n_Rd_o       = nRd_r;
    assign p_Busy_o     = busy_r;
    assign p_ByteSent_o = byteSent_r;
    assign State_o      = stateOh_r;
    assign BitCounter_o = bitCnt_r;
    assign TxByteCnt_o  = byteCnt_r;

endmodule

// File: tb/tb_tx_core_serializer.sv
// Scoreboard bench for tx_core_serializer: stimulus queues FIFO bytes plus the
// hand-computed bit sequence expected on Tx_o; a line monitor decodes frames.
`timescale 1ns/1ps
module tb_tx_core_serializer;

    localparam int CLK_HALF = 5;
    localparam int BAUD_DIV = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        pEnable;
    logic        baudSig;
    logic [7:0]  dataIn;
    logic        pEmpty;
    logic        nRd;
    logic        pParityEnable;
    logic        parityMethod;
    logic        pBigEnd;
    logic        stopBits;
    logic        tx;
    logic        pBusy;
    logic        pByteSent;
    logic [4:0]  state;
    logic [3:0]  bitCounter;
    logic [15:0] txByteCnt;

    typedef struct packed {
        logic [11:0] bits;     // transmission order: bits[nbits-1] goes first
        logic [7:0]  nbits;
        logic [15:0] gapClk;   // expected clocks since previous start, 0 = unchecked
    } frame_t;

    frame_t     expQ[$];
    logic [7:0] fifoQ[$];
    int nChecks   = 0;
    int nFail     = 0;
    int rdCount   = 0;
    int sentCount = 0;
    int cyc       = 0;
    bit monEn     = 1'b1;

    assign pEmpty = (fifoQ.size() == 0);

    tx_core_serializer #(.IDLE_LEVEL(1'b1), .CNT_WIDTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .p_Enable_i       (pEnable),
        .BaudSig_i        (baudSig),
        .Data_i           (dataIn),
        .p_Empty_i        (pEmpty),
        .n_Rd_o           (nRd),
        .p_ParityEnable_i (pParityEnable),
        .ParityMethod_i   (parityMethod),
        .p_BigEnd_i       (pBigEnd),
        .StopBits_i       (stopBits),
        .Tx_o             (tx),
        .p_Busy_o         (pBusy),
        .p_ByteSent_o     (pByteSent),
        .State_o          (state),
        .BitCounter_o     (bitCounter),
        .TxByteCnt_o      (txByteCnt)
    );

    always #CLK_HALF clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Baud pulse: one clock high every BAUD_DIV clocks
    initial begin
        baudSig = 1'b0;
        forever begin
            repeat (BAUD_DIV - 1) @(posedge clk);
            #1 baudSig = 1'b1;
            @(posedge clk);
            #1 baudSig = 1'b0;
        end
    end

    // FIFO model: data valid the cycle after the read strobe
    initial begin
        dataIn = 8'h00;
        forever begin
            @(negedge clk);
            if (nRd === 1'b0) begin
                if (fifoQ.size() != 0) dataIn = fifoQ.pop_front();
                rdCount++;
            end
        end
    end

    // Byte-sent pulse counter
    initial begin
        forever begin
            @(negedge clk);
            if (pByteSent === 1'b1) sentCount++;
        end
    end

    // Line monitor: decode each frame mid-bit and compare with the scoreboard
    initial begin : monitor
        logic        prevTx;
        logic [11:0] got;
        frame_t      item;
        int          startCyc;
        int          lastStart;
        prevTx    = 1'b1;
        lastStart = 0;
        forever begin
            @(negedge clk);
            if (monEn && prevTx === 1'b1 && tx === 1'b0) begin
                startCyc = cyc;
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("FAIL unexpected_frame: start seen at cycle %0d, required none", startCyc);
                    item       = '0;
                    item.nbits = 8'd10;
                end else begin
                    item = expQ.pop_front();
                end
                got = 12'd0;
                for (int i = 0; i < int'(item.nbits); i++) begin
                    repeat ((i == 0) ? 8 : BAUD_DIV) @(negedge clk);
                    got = {got[10:0], tx};
                end
                chk("frame_bits", 32'(got), 32'(item.bits));
                if (item.gapClk != 16'd0)
                    chk("frame_spacing_clk", 32'(startCyc - lastStart), 32'(item.gapClk));
                lastStart = startCyc;
            end
            prevTx = tx;
        end
    end

    task automatic queueByte(input logic [7:0] d, input logic [11:0] bits, input int nb, input int gap);
        frame_t f;
        f.bits   = bits;
        f.nbits  = 8'(nb);
        f.gapClk = 16'(gap);
        expQ.push_back(f);
        fifoQ.push_back(d);
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || pBusy !== 1'b0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) begin
            nChecks++;
            nFail++;
            $display("FAIL timeout_%s: still busy after %0d cycles, required idle", name, n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic waitState(input string name, input logic [4:0] st, input logic [3:0] bc, input bit useBc);
        int n;
        n = 0;
        while (!(state === st && (!useBc || bitCounter === bc)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            nChecks++;
            nFail++;
            $display("FAIL timeout_%s: state %0b never reached, required %0b", name, state, st);
        end
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        pEnable       = 1'b0;
        pParityEnable = 1'b0;
        parityMethod  = 1'b0;
        pBigEnd       = 1'b0;
        stopBits      = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_tx",      tx,         1'b1);
        chk("reset_nrd",     nRd,        1'b1);
        chk("reset_busy",    pBusy,      1'b0);
        chk("reset_sent",    pByteSent,  1'b0);
        chk("reset_state",   state,      5'b00001);
        chk("reset_bitcnt",  bitCounter, 4'd0);
        chk("reset_bytecnt", txByteCnt,  16'd0);
        rst     = 1'b0;
        pEnable = 1'b1;

        // A5, parity off, little-end, one stop
        queueByte(8'hA5, 12'(10'b0_10100101_1), 10, 0);
        waitDone("a5");
        chk("a5_reads",   rdCount,   32'd1);
        chk("a5_sent",    sentCount, 32'd1);
        chk("a5_bytecnt", txByteCnt, 16'd1);

        // 03 with even then odd parity
        pParityEnable = 1'b1;
        parityMethod  = 1'b0;
        queueByte(8'h03, 12'(11'b0_11000000_0_1), 11, 0);
        waitDone("even");
        parityMethod = 1'b1;
        queueByte(8'h03, 12'(11'b0_11000000_1_1), 11, 0);
        waitDone("odd");
        chk("parity_bytecnt", txByteCnt, 16'd3);

        // 80 big-end: first data bit 1, then seven zeros
        pParityEnable = 1'b0;
        pBigEnd       = 1'b1;
        queueByte(8'h80, 12'(10'b0_10000000_1), 10, 0);
        waitDone("bigend");
        chk("bigend_bytecnt", txByteCnt, 16'd4);

        // Three back-to-back frames with two stop bits: starts 12 bit periods apart
        pBigEnd  = 1'b0;
        stopBits = 1'b1;
        queueByte(8'h1E, 12'(11'b0_01111000_11), 11, 0);
        queueByte(8'h0F, 12'(11'b0_11110000_11), 11, 12 * BAUD_DIV);
        queueByte(8'h00, 12'(11'b0_00000000_11), 11, 12 * BAUD_DIV);
        waitDone("b2b");
        chk("b2b_reads",   rdCount,   32'd7);
        chk("b2b_sent",    sentCount, 32'd7);
        chk("b2b_bytecnt", txByteCnt, 16'd7);

        // Reset during data bit 4 aborts the frame
        stopBits = 1'b0;
        monEn    = 1'b0;
        fifoQ.push_back(8'h00);
        waitState("databit4", 5'b00100, 4'd4, 1'b1);
        chk("abort_tx_low", tx, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx",      tx,        1'b1);
        chk("abort_state",   state,     5'b00001);
        chk("abort_busy",    pBusy,     1'b0);
        chk("abort_bytecnt", txByteCnt, 16'd0);
        rst = 1'b0;
        repeat (64) @(negedge clk);
        chk("abort_sent",  sentCount, 32'd7);
        chk("abort_reads", rdCount,   32'd8);
        monEn = 1'b1;

        // Counter wrap, and enable dropped at start bit with two bytes queued
        force dut.byteCnt_r = 16'hFFFF;
        @(negedge clk);
        release dut.byteCnt_r;
        @(negedge clk);
        chk("preset_bytecnt", txByteCnt, 16'hFFFF);
        queueByte(8'hC3, 12'(10'b0_11000011_1), 10, 0);
        fifoQ.push_back(8'h3C);
        waitState("startbit", 5'b00010, 4'd0, 1'b0);
        pEnable = 1'b0;
        waitDone("endrop");
        repeat (64) @(negedge clk);
        chk("endrop_reads",   rdCount,      32'd9);
        chk("endrop_sent",    sentCount,    32'd8);
        chk("wrap_bytecnt",   txByteCnt,    16'd0);
        chk("endrop_fifo",    fifoQ.size(), 32'd1);

        // Re-enable: the remaining byte goes out
        begin
            frame_t f;
            f.bits   = 12'(10'b0_00111100_1);
            f.nbits  = 8'd10;
            f.gapClk = 16'd0;
            expQ.push_back(f);
        end
        pEnable = 1'b1;
        waitDone("resume");
        chk("resume_reads",   rdCount,   32'd10);
        chk("resume_bytecnt", txByteCnt, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
